// File: rtl/debounced_gate_array.sv
// N-channel switch debouncer feeding a mode-selectable reduction (AND/OR/XOR/majority)
// with a saturating transition counter. Define SYNC2_EN to add a two-flop input synchroniser.
module debounced_gate_array #(
    parameter int N_INPUTS        = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_INPUTS-1:0] sw,
    input  logic [1:0]          mode,
    output logic [N_INPUTS-1:0] stable,
    output logic                s,
    output logic [CNT_W-1:0]    toggle_count
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = $clog2(N_INPUTS + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0]    HALF     = PW'(N_INPUTS / 2);
    localparam logic [CNT_W-1:0] TOG_MAX  = '1;

    logic [N_INPUTS-1:0] sw_in;
    logic [N_INPUTS-1:0] stable_w;
    logic                s_reg;
    logic                s_next;
    logic [CNT_W-1:0]    toggle_reg;
    logic [PW-1:0]       pop_count;

`ifdef SYNC2_EN
    logic [N_INPUTS-1:0] sync_meta_reg;
    logic [N_INPUTS-1:0] sync_out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_reg <= '0;
            sync_out_reg  <= '0;
        end else begin
            sync_meta_reg <= sw;
            sync_out_reg  <= sync_meta_reg;
        end
    end

    assign sw_in = sync_out_reg;
`else
    assign sw_in = sw;
`endif

    // Each channel owns its level and run-length counter; any agreeing sample restarts the run.
    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_chan
            logic          chan_stable_reg;
            logic [CW-1:0] chan_cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    chan_stable_reg <= 1'b0;
                    chan_cnt_reg    <= '0;
                end else if (sw_in[gi] == chan_stable_reg) begin
                    chan_cnt_reg <= '0;
                end else if (chan_cnt_reg == CNT_LAST) begin
                    chan_stable_reg <= sw_in[gi];
                    chan_cnt_reg    <= '0;
                end else begin
                    chan_cnt_reg <= chan_cnt_reg + 1'b1;
                end
            end

            assign stable_w[gi] = chan_stable_reg;
        end
    endgenerate

    always_comb begin
        pop_count = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            pop_count = pop_count + PW'(stable_w[i]);
        end
        s_next = 1'b0;
        case (mode)
            2'b00:   s_next = &stable_w;
            2'b01:   s_next = |stable_w;
            2'b10:   s_next = ^stable_w;
            default: s_next = (pop_count > HALF);  // strict: an even-N tie gives 0
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg      <= 1'b0;
            toggle_reg <= '0;
        end else begin
            s_reg <= s_next;
            if ((s_next != s_reg) && (toggle_reg != TOG_MAX)) begin
                toggle_reg <= toggle_reg + 1'b1;
            end
        end
    end

    assign stable       = stable_w;
    assign s            = s_reg;
    assign toggle_count = toggle_reg;
endmodule

// File: tb/tb_debounced_gate_array.sv
// Directed-vector bench for debounced_gate_array: main instance with defaults, plus
// a CNT_W=2 instance for saturation and an N=1/DEBOUNCE_CYCLES=1 instance for the degenerate case.
module tb_debounced_gate_array;
    logic       clk = 1'b0;
    logic       rst, rst2, rst3;
    logic [3:0] sw, sw2;
    logic [0:0] sw3;
    logic [1:0] mode, mode2, mode3;
    logic [3:0] stable, stable2;
    logic [0:0] stable3;
    logic       s, s2, s3;
    logic [7:0] toggle_count;
    logic [1:0] toggle_count2;
    logic [3:0] toggle_count3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debounced_gate_array #(.N_INPUTS(4), .DEBOUNCE_CYCLES(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sw(sw), .mode(mode),
        .stable(stable), .s(s), .toggle_count(toggle_count)
    );

    debounced_gate_array #(.N_INPUTS(4), .DEBOUNCE_CYCLES(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst2), .sw(sw2), .mode(mode2),
        .stable(stable2), .s(s2), .toggle_count(toggle_count2)
    );

    debounced_gate_array #(.N_INPUTS(1), .DEBOUNCE_CYCLES(1), .CNT_W(4)) dut_one (
        .clk(clk), .rst(rst3), .sw(sw3), .mode(mode3),
        .stable(stable3), .s(s3), .toggle_count(toggle_count3)
    );

    typedef struct {
        logic [3:0] sw;
        logic [1:0] mode;
        int         edges;
        logic [3:0] exp_stable;
        logic       exp_s;
        logic [7:0] exp_tog;
    } vec_t;

    vec_t vecs[16];

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic check_main(input string tag, input logic [3:0] es, input logic e_s,
                              input logic [7:0] et);
        check({tag, " stable"}, 32'(stable), 32'(es));
        check({tag, " s"}, 32'(s), 32'(e_s));
        check({tag, " toggle_count"}, 32'(toggle_count), 32'(et));
    endtask

    initial begin
        //           sw       mode   edges stable   s     tog
        vecs[0]  = '{4'b1011, 2'b01, 1, 4'b1011, 1'b1, 8'd1};  // hold
        vecs[1]  = '{4'b0000, 2'b00, 8, 4'b0000, 1'b0, 8'd2};  // AND drops s on edge 1
        vecs[2]  = '{4'b1111, 2'b00, 8, 4'b1111, 1'b0, 8'd2};  // stable lands on edge 8
        vecs[3]  = '{4'b1111, 2'b00, 1, 4'b1111, 1'b1, 8'd3};  // s one edge later
        vecs[4]  = '{4'b0000, 2'b00, 9, 4'b0000, 1'b0, 8'd4};
        vecs[5]  = '{4'b0001, 2'b00, 7, 4'b0000, 1'b0, 8'd4};  // 7-cycle glitch
        vecs[6]  = '{4'b0000, 2'b00, 3, 4'b0000, 1'b0, 8'd4};  // glitch rejected
        vecs[7]  = '{4'b0001, 2'b00, 8, 4'b0001, 1'b0, 8'd4};  // exactly 8 accepted
        vecs[8]  = '{4'b1001, 2'b10, 9, 4'b1001, 1'b0, 8'd6};  // XOR 1 then 0
        vecs[9]  = '{4'b1000, 2'b10, 8, 4'b1000, 1'b0, 8'd6};
        vecs[10] = '{4'b1000, 2'b10, 1, 4'b1000, 1'b1, 8'd7};  // nine edges after sw change
        vecs[11] = '{4'b1000, 2'b00, 1, 4'b1000, 1'b0, 8'd8};  // mode change: 1 edge
        vecs[12] = '{4'b1100, 2'b11, 9, 4'b1100, 1'b0, 8'd8};  // majority tie -> 0
        vecs[13] = '{4'b1110, 2'b11, 8, 4'b1110, 1'b0, 8'd8};
        vecs[14] = '{4'b1110, 2'b11, 1, 4'b1110, 1'b1, 8'd9};  // 3 of 4 -> 1
        vecs[15] = '{4'b1110, 2'b01, 1, 4'b1110, 1'b1, 8'd9};

        rst = 1'b1; sw = 4'b1011; mode = 2'b01;
        rst2 = 1'b1; sw2 = 4'b0000; mode2 = 2'b01;
        rst3 = 1'b1; sw3 = 1'b0; mode3 = 2'b00;
        step(2);
        check_main("reset", 4'b0000, 1'b0, 8'd0);

        rst = 1'b0;
        step(7);
        check_main("post-reset edge7", 4'b0000, 1'b0, 8'd0);
        step(1);
        check_main("post-reset edge8", 4'b1011, 1'b0, 8'd0);
        step(1);
        check_main("post-reset edge9", 4'b1011, 1'b1, 8'd1);

        for (int v = 0; v < 16; v++) begin
            sw = vecs[v].sw;
            mode = vecs[v].mode;
            step(vecs[v].edges);
            check_main($sformatf("vec%0d", v), vecs[v].exp_stable, vecs[v].exp_s, vecs[v].exp_tog);
        end

        // Reset halfway through a debounce must discard the partial run.
        sw = 4'b0001; mode = 2'b01;
        step(4);
        check("mid-debounce stable", 32'(stable), 32'(4'b1110));
        rst = 1'b1;
        step(1);
        check_main("mid-debounce reset", 4'b0000, 1'b0, 8'd0);
        rst = 1'b0;
        step(7);
        check("fresh run edge7", 32'(stable), 32'(4'b0000));
        step(1);
        check("fresh run edge8", 32'(stable), 32'(4'b0001));
        step(1);
        check("fresh run s", 32'(s), 32'(1'b1));

        // Saturation: CNT_W=2 counter stops at 3 after five s toggles.
        rst2 = 1'b0; sw2 = 4'b0001; mode2 = 2'b01;
        step(9);
        check("sat toggle1", 32'(toggle_count2), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            mode2 = (k % 2 == 0) ? 2'b00 : 2'b01;
            step(1);
            check($sformatf("sat s%0d", k), 32'(s2), 32'(k % 2));
            check($sformatf("sat toggle%0d", k), 32'(toggle_count2), 32'((k > 3) ? 3 : k));
        end

        // N=1, DEBOUNCE_CYCLES=1: stable follows sw after one edge, every mode passes it.
        rst3 = 1'b0; sw3 = 1'b1;
        step(1);
        check("one stable", 32'(stable3), 32'd1);
        for (int m = 0; m < 4; m++) begin
            mode3 = 2'(m);
            step(1);
            check($sformatf("one mode%0d s", m), 32'(s3), 32'd1);
        end
        sw3 = 1'b0;
        step(2);
        check("one s fall", 32'(s3), 32'd0);
        check("one toggles", 32'(toggle_count3), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
